// File: rtl/gtp_link_model_pkg.sv
// Shared constants, lane state encoding and a constant-width helper
// for the multi-lane GTP link model.
`timescale 1ns/1ps
package gtp_link_pkg;

  localparam logic [15:0] IDLE_DATA = 16'hBCBC;
  localparam logic [1:0]  IDLE_K    = 2'b11;

  typedef enum logic [1:0] {DOWN, TRAIN, UP} lane_state_t;

  // Ceiling log2; callers pass value >= 2 so the result is never zero.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gtp_link_model_if.sv
// Bundles the GTP-facing and control signals of the link model;
// master is the bench/user side, slave is the link model.
`timescale 1ns/1ps
interface gtp_link_model_if #(
  parameter int NUM_GTP = 4,
  parameter int RW      = 4
);

  logic [NUM_GTP-1:0]    lane_en;
  logic [NUM_GTP*RW-1:0] route;
  logic [NUM_GTP-1:0]    inj_err;
  logic [16*NUM_GTP-1:0] gtp_txd;
  logic [2*NUM_GTP-1:0]  gtp_txk;
  logic                  gtp_rdy;
  logic [NUM_GTP-1:0]    gtp_aligned;
  logic [16*NUM_GTP-1:0] gtp_rxd;
  logic [2*NUM_GTP-1:0]  gtp_rxk;
  logic [15:0]           err_cnt;

  modport master (
    output lane_en, route, inj_err, gtp_txd, gtp_txk,
    input  gtp_rdy, gtp_aligned, gtp_rxd, gtp_rxk, err_cnt
  );

  modport slave (
    input  lane_en, route, inj_err, gtp_txd, gtp_txk,
    output gtp_rdy, gtp_aligned, gtp_rxd, gtp_rxk, err_cnt
  );

endinterface

// File: rtl/gtp_lane_fsm.sv
// Per-RX-lane alignment FSM: DOWN -> TRAIN -> UP, with a registered
// aligned flag that tracks the UP state.
`timescale 1ns/1ps
module gtp_lane_fsm
  import gtp_link_pkg::*;
#(
  parameter int ALIGN_DELAY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic gtp_rdy,
  input  logic lane_ok,
  output logic aligned
);

  localparam int CW = clog2(ALIGN_DELAY + 1);

  lane_state_t     state;
  logic [CW-1:0]   train_cnt;

  // aligned is updated on the same edge that enters or leaves UP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DOWN;
      train_cnt <= '0;
      aligned   <= 1'b0;
    end else begin
      case (state)
        DOWN: begin
          if (gtp_rdy && lane_ok) begin
            state     <= TRAIN;
            train_cnt <= '0;
          end
        end
        TRAIN: begin
          if (!lane_ok) begin
            state <= DOWN;
          end else if (train_cnt == CW'(ALIGN_DELAY - 1)) begin
            state   <= UP;
            aligned <= 1'b1;
          end else begin
            train_cnt <= train_cnt + 1'b1;
          end
        end
        UP: begin
          if (!lane_ok) begin
            state   <= DOWN;
            aligned <= 1'b0;
          end
        end
        default: begin
          state   <= DOWN;
          aligned <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gtp_link_model.sv
// Multi-lane GTP link model: routes any TX lane to any RX lane through a
// LAT-deep pipeline, models bring-up timing and single-word error injection.
`timescale 1ns/1ps
module gtp_link_model
  import gtp_link_pkg::*;
#(
  parameter int NUM_GTP     = 4,
  parameter int LAT         = 1,
  parameter int RDY_DELAY   = 16,
  parameter int ALIGN_DELAY = 4,
  parameter int RW          = 4
) (
  input logic             clk,
  input logic             rst,
  gtp_link_model_if.slave bus
);

  localparam int RCW = clog2(RDY_DELAY + 1);

  logic [RCW-1:0]     rdy_cnt;
  logic               gtp_rdy;
  logic [NUM_GTP-1:0] aligned;
  logic [NUM_GTP-1:0] lane_ok;
  logic [NUM_GTP-1:0] inj_applied;
  logic [4:0]         inj_count;
  logic [16:0]        err_sum;
  logic [15:0]        err_cnt;

  // gtp_rdy is sticky; the counter freezes once it has done its job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_cnt <= '0;
      gtp_rdy <= 1'b0;
    end else if (!gtp_rdy) begin
      rdy_cnt <= rdy_cnt + 1'b1;
      if (rdy_cnt == RCW'(RDY_DELAY - 1)) gtp_rdy <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_GTP; i++) begin : g_lane
    logic [RW-1:0] sel;
    logic [17:0]   src;
    logic [17:0]   stage [LAT];
    logic          err_flag;

    assign sel            = bus.route[i*RW +: RW];
    assign lane_ok[i]     = bus.lane_en[i] && (int'(sel) < NUM_GTP);
    assign inj_applied[i] = bus.inj_err[i] & aligned[i];

    always_comb begin
      src = {IDLE_K, IDLE_DATA};
      for (int j = 0; j < NUM_GTP; j++) begin
        if (int'(sel) == j) src = {bus.gtp_txk[2*j +: 2], bus.gtp_txd[16*j +: 16]};
      end
    end

    // The pipeline keeps shifting even while the lane is not UP.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < LAT; s++) stage[s] <= {IDLE_K, IDLE_DATA};
        err_flag <= 1'b0;
      end else begin
        stage[0] <= src;
        for (int s = 1; s < LAT; s++) stage[s] <= stage[s-1];
        err_flag <= inj_applied[i];
      end
    end

    gtp_lane_fsm #(.ALIGN_DELAY(ALIGN_DELAY)) u_fsm (
      .clk     (clk),
      .rst     (rst),
      .gtp_rdy (gtp_rdy),
      .lane_ok (lane_ok[i]),
      .aligned (aligned[i])
    );

    assign bus.gtp_rxd[16*i +: 16] = aligned[i] ? (stage[LAT-1][15:0] ^ {15'd0, err_flag})
                                                : IDLE_DATA;
    assign bus.gtp_rxk[2*i +: 2]   = aligned[i] ? stage[LAT-1][17:16] : IDLE_K;
  end

  always_comb begin
    inj_count = '0;
    for (int i = 0; i < NUM_GTP; i++) inj_count = inj_count + 5'(inj_applied[i]);
  end

  assign err_sum = {1'b0, err_cnt} + 17'(inj_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt <= '0;
    else     err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  assign bus.gtp_rdy     = gtp_rdy;
  assign bus.gtp_aligned = aligned;
  assign bus.err_cnt     = err_cnt;

endmodule
